booth_mult_arbiter: RTL and testbench

Shares one radix4_booth_multiplier instance between NUM_REQ requesters. A round-robin arbiter grants one request at a time, and an FSM sequences the multiplier's start/ready handshake. The product is returned on a shared response channel tagged with the requester id. The block sits between the requester-side logic (for example, per-channel operand sources) and the multiplier datapath, which it instantiates internally.

---
 rtl/booth_arbiter_pkg.sv | 19 +
 rtl/radix4_booth_multiplier.sv | 89 ++++++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/booth_mult_arbiter.sv | 114 +++++++++++
 tb/tb_booth_mult_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_arbiter_pkg.sv
// Shared definitions for the booth multiplier arbiter slice.
//   state_t  : sequencing states of the arbiter FSM
//   id_width : width of a requester index, never less than one bit
package booth_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // A lone requester would still need a one-bit id so the ports stay legal.
  function automatic int id_width(input int numReq);
    return (numReq <= 2) ? 1 : $clog2(numReq);
  endfunction

endpackage

// File: rtl/radix4_booth_multiplier.sv
// Iterative radix-4 Booth multiplier, one Booth digit per enabled cycle.
//   clk_i, rst_ni    : clock and asynchronous active-low reset
//   en_i             : when low all state holds
//   start_i          : load operands while ready_o is high
//   multiplier_i     : signed multiplier operand
//   multiplicand_i   : signed multiplicand operand
//   ready_o          : high when idle; drops the cycle after start
//   product_o        : full-width signed product, valid once ready_o rises again
module radix4_booth_multiplier #(
  parameter int WIDTH       = 8,
  parameter int CHECK_PARAM = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int PW   = 2 * WIDTH;
  localparam int ND   = (WIDTH + 1) / 2;
  localparam int MB   = 2 * ND + 1;
  localparam int CW   = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  if (CHECK_PARAM != 0 && WIDTH == 0) begin : gBadWidth
    $fatal(1, "radix4_booth_multiplier: WIDTH must be non-zero");
  end

  logic [PW-1:0] acc_q, acc_d, mcand_q, product_q, pp;
  logic [MB-1:0] mplier_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // Booth recoding of the three lowest multiplier bits into a partial
  // product of 0, +-1 or +-2 times the (already shifted) multiplicand.
  // Everything is modulo 2^PW, which is exact because the true product fits.
  always_comb begin
    pp = '0;
    unique case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_d = acc_q + pp;
  end

  // Load on start, then consume two multiplier bits per cycle; the last
  // digit writes the product register directly so it appears with ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      product_q <= '0;
    end else if (en_i) begin
      if (!busy_q) begin
        if (start_i) begin
          acc_q    <= '0;
          mcand_q  <= PW'($signed(multiplicand_i));
          mplier_q <= MB'($signed({multiplier_i, 1'b0}));
          cnt_q    <= '0;
          busy_q   <= 1'b1;
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 2;
        mplier_q <= {{2{mplier_q[MB-1]}}, mplier_q[MB-1:2]};
        if (cnt_q == LAST) begin
          busy_q    <= 1'b0;
          product_q <= acc_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign ready_o   = !busy_q;
  assign product_o = product_q;

endmodule

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
//   req_i       : request vector, one bit per requester
//   ptr_i       : index that currently holds highest priority
//   enable_i    : when low no grant is produced
//   grant_o     : one-hot grant (or zero)
//   grant_idx_o : binary index of the granted requester (0 when no grant)
module rr_arbiter
  import booth_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [id_width(NUM_REQ)-1:0]     ptr_i,
  input  logic                             enable_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [id_width(NUM_REQ)-1:0]     grant_idx_o
);

  localparam int IDW = id_width(NUM_REQ);

  // Walk the requesters starting at the pointer and wrapping around; the
  // first one found active wins, so exactly one grant can ever be raised.
  always_comb begin
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      logic [IDW-1:0] idxW;
      idx = int'(ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idxW = IDW'(idx);
      if (enable_i && !found && req_i[idxW]) begin
        found             = 1'b1;
        grant_o[idxW]     = 1'b1;
        grant_idx_o       = idxW;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one radix-4 Booth multiplier between NUM_REQ requesters.
//   clk, rst_n        : clock and asynchronous active-low reset
//   en                : global enable, freezes everything when low
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_multiplier    : per-requester multiplier operand
//   req_multiplicand  : per-requester multiplicand operand
//   rsp_valid/ready   : response handshake
//   rsp_id            : requester that owns rsp_product
//   rsp_product       : full-width signed product
//   busy              : high whenever the FSM is not IDLE
module booth_mult_arbiter
  import booth_arbiter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 4,
  parameter int CHECK_PARAM = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_multiplier,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_multiplicand,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]      rsp_id,
  output logic [2*WIDTH-1:0]                rsp_product,
  output logic                              busy
);

  localparam int IDW = id_width(NUM_REQ);

  if (CHECK_PARAM != 0 && (WIDTH == 0 || NUM_REQ < 2)) begin : gBadParams
    $fatal(1, "booth_mult_arbiter: need WIDTH > 0 and NUM_REQ >= 2");
  end

  state_t               state_q;
  logic [IDW-1:0]       ptr_q, ptr_d, id_q, grantIdx;
  logic [WIDTH-1:0]     opMultiplier_q, opMultiplicand_q;
  logic [2*WIDTH-1:0]   rspProduct_q, mulProduct;
  logic [NUM_REQ-1:0]   grant;
  logic                 arbEnable, accept, mulStart, mulReady;

  // Requests are only offered while idle and enabled, so a grant here is
  // always a completed transfer at the next edge.
  assign arbEnable = en && (state_q == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .enable_i    (arbEnable),
    .grant_o     (grant),
    .grant_idx_o (grantIdx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign ptr_d     = (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;

  radix4_booth_multiplier #(.WIDTH(WIDTH), .CHECK_PARAM(CHECK_PARAM)) u_mul (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .start_i        (mulStart),
    .multiplier_i   (opMultiplier_q),
    .multiplicand_i (opMultiplicand_q),
    .ready_o        (mulReady),
    .product_o      (mulProduct)
  );

  // Sequencer: latch the winner, pulse start, wait for the multiplier to
  // go busy and then done, and hold the response until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      id_q             <= '0;
      opMultiplier_q   <= '0;
      opMultiplicand_q <= '0;
      rspProduct_q     <= '0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            opMultiplier_q   <= req_multiplier[grantIdx];
            opMultiplicand_q <= req_multiplicand[grantIdx];
            id_q             <= grantIdx;
            ptr_q            <= ptr_d;
            state_q          <= LAUNCH;
          end
        end
        LAUNCH:    state_q <= WAIT_BUSY;
        WAIT_BUSY: if (!mulReady) state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (mulReady) begin
            rspProduct_q <= mulProduct;
            state_q      <= RESP;
          end
        end
        RESP:      if (rsp_ready) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Outputs are straight decodes of registered state, so they are glitch-free.
  assign mulStart    = (state_q == LAUNCH);
  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_id      = id_q;
  assign rsp_product = rspProduct_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter (WIDTH=8, NUM_REQ=4).
module tb_booth_mult_arbiter;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_multiplier;
  logic [3:0][7:0]  req_multiplicand;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_product;
  logic             busy;

  int assertCount = 0;
  int failCount   = 0;
  int startCount  = 0;
  int grantCount  = 0;
  int cycles;
  int saveStart, saveGrant;
  logic sawRsp;
  logic [3:0]  expOh;
  logic [15:0] expProd [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

  booth_mult_arbiter #(.WIDTH(8), .NUM_REQ(4), .CHECK_PARAM(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product),
    .busy             (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count multiplier start pulses and completed request transfers.
  always @(posedge clk) begin
    if (rst_n && en) begin
      if (dut.mulStart) startCount++;
      if (|req_ready) grantCount++;
    end
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic valid,
                               input logic [7:0] a, input logic [7:0] b);
    req_valid[idx]        = valid;
    req_multiplier[idx]   = a;
    req_multiplicand[idx] = b;
  endtask

  task automatic dropValid(input logic [1:0] idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until rsp_valid, giving up after 60.
  task automatic waitRsp(output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      nextCycle();
      n++;
    end
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; rsp_ready = 1'b0;
    req_valid = '0; req_multiplier = '0; req_multiplicand = '0;
    repeat (3) nextCycle();

    // Reset state
    checkOutput("reset_outputs", {busy, rsp_valid, req_ready, rsp_id, rsp_product}, 32'd0);
    checkOutput("reset_start", startCount, 0);
    rst_n = 1'b1;
    nextCycle();

    // Single request: requester 2, 4 x -3
    applyStimulus(2'd2, 1'b1, 8'd4, 8'hFD);
    #1 checkOutput("single_grant", req_ready, 4'b0100);
    @(posedge clk); nextCycle();
    dropValid(2'd2);
    checkOutput("single_ready_low", {busy, req_ready}, 5'b1_0000);
    waitRsp(cycles);
    checkOutput("single_latency", cycles, 6);
    checkOutput("single_id", rsp_id, 2);
    checkOutput("single_product", rsp_product, 16'hFFF4);
    checkOutput("single_starts", startCount, 1);
    checkOutput("single_grants", grantCount, 1);
    rsp_ready = 1'b1;
    nextCycle();
    checkOutput("single_rsp_done", {rsp_valid, busy}, 2'b00);

    // All four at once, twice, from pointer 0
    resetPulse();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        applyStimulus(2'(i), 1'b1, 8'(i + 1), 8'd10);
      for (int i = 0; i < 4; i++) begin
        expOh = 4'b0001 << i;
        #1 checkOutput($sformatf("rr%0d_grant%0d", r, i), req_ready, expOh);
        @(posedge clk); nextCycle();
        dropValid(2'(i));
        waitRsp(cycles);
        checkOutput($sformatf("rr%0d_id%0d", r, i), rsp_id, i);
        checkOutput($sformatf("rr%0d_prod%0d", r, i), rsp_product, expProd[i]);
        nextCycle();
      end
    end

    // Extremes on requesters 0, 1, 2
    applyStimulus(2'd0, 1'b1, 8'h80, 8'h80);
    @(posedge clk); nextCycle(); dropValid(2'd0);
    waitRsp(cycles);
    checkOutput("ext_minmin", rsp_product, 16'h4000);
    nextCycle();
    applyStimulus(2'd1, 1'b1, 8'h80, 8'h7F);
    @(posedge clk); nextCycle(); dropValid(2'd1);
    waitRsp(cycles);
    checkOutput("ext_minmax", rsp_product, 16'hC080);
    nextCycle();
    applyStimulus(2'd2, 1'b1, 8'h00, 8'hFF);
    @(posedge clk); nextCycle(); dropValid(2'd2);
    waitRsp(cycles);
    checkOutput("ext_zero", {rsp_id, rsp_product}, {2'd2, 16'h0000});
    nextCycle();

    // Backpressure: response from requester 3 held, requester 1 pending
    rsp_ready = 1'b0;
    applyStimulus(2'd3, 1'b1, 8'd5, 8'd6);
    #1 checkOutput("bp_grant3", req_ready, 4'b1000);
    @(posedge clk); nextCycle(); dropValid(2'd3);
    waitRsp(cycles);
    applyStimulus(2'd1, 1'b1, 8'd7, 8'hFE);
    for (int k = 0; k < 20; k++) begin
      #1 checkOutput($sformatf("bp_hold%0d", k),
                     {rsp_valid, req_ready, rsp_id, rsp_product},
                     {1'b1, 4'b0000, 2'd3, 16'h001E});
      nextCycle();
    end
    rsp_ready = 1'b1;
    @(posedge clk); nextCycle();
    #1 checkOutput("bp_release_grant", {rsp_valid, req_ready}, 5'b0_0010);
    @(posedge clk); nextCycle(); dropValid(2'd1);
    waitRsp(cycles);
    checkOutput("bp_latency", cycles, 6);
    checkOutput("bp_result", {rsp_id, rsp_product}, {2'd1, 16'hFFF2});
    nextCycle();

    // Enable stall during WAIT_DONE; pointer is now 2
    applyStimulus(2'd2, 1'b1, 8'd9, 8'hF9);
    #1 checkOutput("stall_grant", req_ready, 4'b0100);
    @(posedge clk); nextCycle(); dropValid(2'd2);
    nextCycle(); nextCycle();
    en = 1'b0;
    saveStart = startCount;
    saveGrant = grantCount;
    applyStimulus(2'd0, 1'b1, 8'd2, 8'hFF);
    applyStimulus(2'd3, 1'b1, 8'd3, 8'd3);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput($sformatf("stall_frozen%0d", k), {busy, rsp_valid, req_ready}, 6'b10_0000);
    end
    checkOutput("stall_no_start", startCount, saveStart);
    checkOutput("stall_no_grant", grantCount, saveGrant);
    en = 1'b1;
    waitRsp(cycles);
    checkOutput("stall_resume_cycles", cycles, 4);
    checkOutput("stall_result", {rsp_id, rsp_product}, {2'd2, 16'hFFC1});
    nextCycle();
    #1 checkOutput("stall_ptr_next", req_ready, 4'b1000);
    @(posedge clk); nextCycle(); dropValid(2'd3);
    waitRsp(cycles);
    checkOutput("stall_r3", {rsp_id, rsp_product}, {2'd3, 16'h0009});
    nextCycle();
    #1 checkOutput("stall_ptr_wrap", req_ready, 4'b0001);
    @(posedge clk); nextCycle(); dropValid(2'd0);
    waitRsp(cycles);
    checkOutput("stall_r0", {rsp_id, rsp_product}, {2'd0, 16'hFFFE});
    nextCycle();

    // Asynchronous reset in WAIT_DONE; pointer would be 3 without it
    applyStimulus(2'd2, 1'b1, 8'd11, 8'd11);
    @(posedge clk); nextCycle(); dropValid(2'd2);
    nextCycle(); nextCycle();
    #2 rst_n = 1'b0;
    #1 checkOutput("areset_outputs", {busy, rsp_valid, req_ready, rsp_id, rsp_product}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    sawRsp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("areset_no_rsp", sawRsp, 1'b0);
    applyStimulus(2'd1, 1'b1, 8'hFB, 8'd12);
    applyStimulus(2'd3, 1'b1, 8'd1, 8'd1);
    #1 checkOutput("areset_ptr0_grant", req_ready, 4'b0010);
    @(posedge clk); nextCycle(); dropValid(2'd1);
    waitRsp(cycles);
    checkOutput("areset_result", {rsp_id, rsp_product}, {2'd1, 16'hFFC4});
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
